// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback arbiter priority encoding.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 2;
  localparam int unsigned NUM_REGS   = 4;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: req[0]=ALU, req[1]=LSU; pointer names the favoured side.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  pri_e       pri,
  output logic [1:0] grant,
  output pri_e       pri_next
);

  always_comb begin
    grant    = '0;
    pri_next = pri;
    if (req == 2'b11) begin
      grant = (pri == PRI_ALU) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
    // The pointer always moves to whoever lost, so a held request waits at most one cycle.
    if (grant[0]) begin
      pri_next = PRI_LSU;
    end else if (grant[1]) begin
      pri_next = PRI_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and LSU writeback and
// tracks outstanding destinations for read-after-write hazard detection.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = regfile_pkg::XLEN,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [XLEN-1:0]     lsu_data,
  input  logic                mark_valid,
  input  logic [ADDR_W-1:0]   mark_addr,
  input  logic [ADDR_W-1:0]   rs_a,
  input  logic [ADDR_W-1:0]   rs_b,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  pri_e                  pri_q;
  pri_e                  pri_d;
  logic [1:0]            grant;
  logic [NUM_REGS-1:1]   busy_q;

  rr_arb2 u_arb (
    .req      ({lsu_valid, alu_valid}),
    .pri      (pri_q),
    .grant    (grant),
    .pri_next (pri_d)
  );

  assign alu_ready = grant[0] && !reset;
  assign lsu_ready = grant[1] && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q <= PRI_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant[0]) begin
      rf_we    <= (alu_addr != ZERO_ADDR);
      rf_waddr <= alu_addr;
      rf_wdata <= alu_data;
    end else if (grant[1]) begin
      rf_we    <= (lsu_addr != ZERO_ADDR);
      rf_waddr <= lsu_addr;
      rf_wdata <= lsu_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Set takes priority over clear: a fresh mark means a newer producer is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (mark_valid && mark_addr == ADDR_W'(i)) begin
          busy_q[i] <= 1'b1;
        end else if (rf_we && rf_waddr == ADDR_W'(i)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign busy   = {busy_q, 1'b0};
  assign hazard = ((rs_a != ZERO_ADDR) && busy[rs_a]) ||
                  ((rs_b != ZERO_ADDR) && busy[rs_b]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [1:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [1:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        mark_valid;
  logic [1:0]  mark_addr;
  logic [1:0]  rs_a;
  logic [1:0]  rs_b;
  logic        hazard;
  logic [3:0]  busy;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .XLEN     (32),
    .ADDR_W   (2),
    .NUM_REGS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .mark_valid (mark_valid),
    .mark_addr  (mark_addr),
    .rs_a       (rs_a),
    .rs_b       (rs_b),
    .hazard     (hazard),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    mark_valid = 1'b0; mark_addr = '0; rs_a = '0; rs_b = '0;
    step(); step();

    alu_valid = 1'b1;
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_busy", busy, 0);
    step();

    // ALU-only write
    reset = 1'b0; alu_valid = 1'b1; alu_addr = 2; alu_data = 32'hDEADBEEF;
    #1;
    check("alu_ready", alu_ready, 1);
    check("alu_lsu_ready", lsu_ready, 0);
    step();
    alu_valid = 1'b0;
    check("alu_rf_we", rf_we, 1);
    check("alu_rf_waddr", rf_waddr, 2);
    check("alu_rf_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    check("alu_rf_we_off", rf_we, 0);
    check("alu_waddr_hold", rf_waddr, 2);
    check("alu_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // Contention from a fresh reset
    reset = 1'b1; step(); reset = 1'b0;
    alu_valid = 1'b1; alu_addr = 1; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_addr = 3; lsu_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_alu_ready", alu_ready, (k % 2 == 0) ? 1 : 0);
      check("cont_lsu_ready", lsu_ready, (k % 2 == 0) ? 0 : 1);
      step();
      if (k == 3) begin
        alu_valid = 1'b0; lsu_valid = 1'b0;
      end
      check("cont_rf_we", rf_we, 1);
      check("cont_rf_waddr", rf_waddr, (k % 2 == 0) ? 1 : 3);
      check("cont_rf_wdata", rf_wdata, (k % 2 == 0) ? 32'hA : 32'hB);
    end
    step();
    check("cont_idle_we", rf_we, 0);

    // Scoreboard mark, hazard, then clear two cycles after the LSU transfer
    mark_valid = 1'b1; mark_addr = 3;
    step();
    mark_valid = 1'b0; rs_a = 3;
    #1;
    check("sb_busy3", busy, 4'b1000);
    check("sb_hazard_set", hazard, 1);
    lsu_valid = 1'b1; lsu_addr = 3; lsu_data = 32'h33;
    #1;
    check("sb_lsu_ready", lsu_ready, 1);
    check("sb_hazard_n", hazard, 1);
    step();
    lsu_valid = 1'b0;
    check("sb_rf_we", rf_we, 1);
    check("sb_hazard_n1", hazard, 1);
    step();
    check("sb_hazard_n2", hazard, 0);
    check("sb_busy_clear", busy, 0);

    // Set beats clear on the same register
    rs_a = 0; rs_b = 1;
    mark_valid = 1'b1; mark_addr = 1;
    step();
    mark_valid = 1'b0;
    check("sbc_busy1", busy, 4'b0010);
    alu_valid = 1'b1; alu_addr = 1; alu_data = 32'h11;
    step();
    alu_valid = 1'b0; mark_valid = 1'b1; mark_addr = 1;
    check("sbc_rf_we", rf_we, 1);
    check("sbc_rf_waddr", rf_waddr, 1);
    step();
    mark_valid = 1'b0;
    check("sbc_busy_kept", busy, 4'b0010);
    check("sbc_hazard", hazard, 1);

    // Zero register
    reset = 1'b1; step(); reset = 1'b0;
    rs_a = 0; rs_b = 0;
    alu_valid = 1'b1; alu_addr = 0; alu_data = 32'h12345678;
    mark_valid = 1'b1; mark_addr = 0;
    #1;
    check("zero_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0; mark_valid = 1'b0;
    check("zero_rf_we", rf_we, 0);
    check("zero_busy", busy, 0);
    check("zero_hazard", hazard, 0);

    // Reset the cycle after a grant; pointer currently favours LSU
    alu_valid = 1'b1; alu_addr = 2; alu_data = 32'h5;
    mark_valid = 1'b1; mark_addr = 2;
    #1;
    check("mid_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0; mark_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rf_we", rf_we, 0);
    check("mid_busy", busy, 0);
    alu_valid = 1'b1; alu_addr = 1; alu_data = 32'hC;
    lsu_valid = 1'b1; lsu_addr = 3; lsu_data = 32'hD;
    #1;
    check("mid_first_alu", alu_ready, 1);
    check("mid_first_lsu", lsu_ready, 0);
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("mid_rf_waddr", rf_waddr, 1);
    check("mid_rf_wdata", rf_wdata, 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
